// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, one-entry fetch buffer and IF/ID pipeline register.
// Optional performance counters are enabled with the IF_STAGE_PERF_EN macro.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        ifid_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] bubble_cnt
);

  logic [31:0] pc;
  logic [31:0] pc_next4;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic        advance;
  logic        redirect;
  logic        fetch_ok;
  logic [31:0] fetched;

  assign advance   = pc_write & ifid_write;
  assign redirect  = branch_taken | ifid_flush;
  assign fetch_ok  = buf_valid | imem_ready;
  assign fetched   = buf_valid ? buf_instr : imem_rdata;
  assign pc_next4  = pc + 32'd4;
  assign imem_req  = ~buf_valid & ~rst;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (advance && fetch_ok) begin
      pc <= pc_next4;
    end
  end

  // A missing instruction while IF/ID loads is treated like a flush: insert a bubble.
  always_ff @(posedge clk) begin
    if (rst || redirect || (ifid_write && !fetch_ok)) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= 32'h0;
      ifid_pc4   <= 32'h0;
    end else if (ifid_write) begin
      ifid_valid <= 1'b1;
      ifid_instr <= fetched;
      ifid_pc    <= pc;
      ifid_pc4   <= pc_next4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_instr <= 32'h0;
    end else if (redirect) begin
      buf_valid <= 1'b0;
    end else if (buf_valid) begin
      if (advance) buf_valid <= 1'b0;
    end else if (imem_ready && !advance) begin
      buf_valid <= 1'b1;
      buf_instr <= imem_rdata;
    end
  end

`ifdef IF_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 32'h0;
      flush_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (!advance && !redirect) stall_cnt <= stall_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 32'd1;
      if (ifid_write && !redirect && !fetch_ok) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt  = 32'h0;
  assign flush_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`ifdef IF_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0, ifid_write = 1'b0, ifid_flush = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic [31:0] stall_cnt, flush_cnt, bubble_cnt;

  int total = 0;
  int bad = 0;

  // behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_buf[$];
  logic        m_iv;
  logic [31:0] m_ii, m_ip, m_ip4;
  logic [31:0] m_stall, m_flush, m_bubble;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic model_step();
    logic adv, redir, have;
    logic [31:0] word;
    if (rst) begin
      m_pc = RESET_PC; m_buf.delete();
      m_iv = 1'b0; m_ii = NOP_INSTR; m_ip = 32'h0; m_ip4 = 32'h0;
      m_stall = 0; m_flush = 0; m_bubble = 0;
      return;
    end
    adv   = pc_write & ifid_write;
    redir = branch_taken | ifid_flush;
    have  = (m_buf.size() != 0) || imem_ready;
    word  = (m_buf.size() != 0) ? m_buf[0] : mem_word(m_pc);
    if (!adv && !redir) m_stall++;
    if (redir) m_flush++;
    if (ifid_write && !redir && !have) m_bubble++;
    if (redir || (ifid_write && !have)) begin
      m_iv = 1'b0; m_ii = NOP_INSTR; m_ip = 32'h0; m_ip4 = 32'h0;
    end else if (ifid_write) begin
      m_iv = 1'b1; m_ii = word; m_ip = m_pc; m_ip4 = m_pc + 32'd4;
    end
    if (redir) m_buf.delete();
    else if (m_buf.size() != 0) begin
      if (adv) m_buf.delete();
    end else if (imem_ready && !adv) m_buf.push_back(mem_word(m_pc));
    if (branch_taken) m_pc = branch_target;
    else if (adv && have) m_pc = m_pc + 32'd4;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic pw, input logic iw, input logic fl, input logic bt,
                       input logic [31:0] tgt, input logic rdy);
    pc_write = pw; ifid_write = iw; ifid_flush = fl; branch_taken = bt;
    branch_target = tgt; imem_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 0);
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 1, 1, 32'h40, 1);
    cycle(); cycle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    total++; if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b0, NOP_INSTR, 64'h0}) begin
      bad++; $display("FAIL reset_ifid got=%b %h %h %h", ifid_valid, ifid_instr, ifid_pc, ifid_pc4); end
    total++; if ({stall_cnt, flush_cnt, bubble_cnt} !== 96'h0) begin
      bad++; $display("FAIL reset_cnt got=%h %h %h exp=0", stall_cnt, flush_cnt, bubble_cnt); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0);
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_release_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_stream();
    do_reset();
    drive(1, 1, 0, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++; if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'(4 * i), mem_word(32'(4 * i))}) begin
        bad++; $display("FAIL stream_%0d got=%b %h %h exp pc=%h", i, ifid_valid, ifid_pc, ifid_instr, 4 * i); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 1, 0, 0, 32'h0, 1);
    cycle(); cycle();
    drive(0, 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if ({imem_req, imem_addr, ifid_pc} !== {1'b0, 32'h8, 32'h4}) begin
        bad++; $display("FAIL stall_%0d got req=%b addr=%h ifid_pc=%h exp 0 8 4", i, imem_req, imem_addr, ifid_pc); end
    end
    drive(1, 1, 0, 0, 32'h0, 0);
    cycle();
    total++; if ({ifid_valid, ifid_pc, ifid_instr, imem_addr} !== {1'b1, 32'h8, mem_word(32'h8), 32'hC}) begin
      bad++; $display("FAIL stall_release got=%b %h %h addr=%h", ifid_valid, ifid_pc, ifid_instr, imem_addr); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1, 1, 0, 1, 32'h20, 1);
    cycle();
    total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL branch_pre got=%h exp=20", imem_addr); end
    drive(1, 1, 1, 1, 32'h100, 1);
    cycle();
    total++; if ({ifid_valid, ifid_instr, imem_addr} !== {1'b0, 32'h13, 32'h100}) begin
      bad++; $display("FAIL branch_flush got=%b %h addr=%h", ifid_valid, ifid_instr, imem_addr); end
    drive(1, 1, 0, 0, 32'h0, 1);
    cycle();
    drive(0, 0, 0, 0, 32'h0, 1);
    cycle();
    drive(0, 0, 0, 1, 32'h200, 1);
    cycle();
    total++; if ({ifid_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      bad++; $display("FAIL branch_stalled got=%b req=%b addr=%h", ifid_valid, imem_req, imem_addr); end
  endtask

  task automatic test_wait_states();
    do_reset();
    drive(1, 1, 0, 0, 32'h0, 1);
    cycle();
    drive(1, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++; if ({ifid_valid, imem_addr} !== {1'b0, 32'h4}) begin
        bad++; $display("FAIL wait_%0d got=%b addr=%h exp 0 4", i, ifid_valid, imem_addr); end
    end
    drive(1, 1, 0, 0, 32'h0, 1);
    cycle();
    total++; if ({ifid_valid, ifid_pc} !== {1'b1, 32'h4}) begin
      bad++; $display("FAIL wait_release got=%b %h exp 1 4", ifid_valid, ifid_pc); end
    total++; if (bubble_cnt !== (PERF ? 32'd2 : 32'd0)) begin
      bad++; $display("FAIL wait_bubble_cnt got=%0d exp=%0d", bubble_cnt, PERF ? 2 : 0); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    drive(1, 1, 0, 1, 32'hFFFF_FFFC, 1);
    cycle();
    drive(1, 1, 0, 0, 32'h0, 1);
    cycle();
    total++; if ({ifid_pc, ifid_pc4, imem_addr} !== {32'hFFFF_FFFC, 32'h0, 32'h0}) begin
      bad++; $display("FAIL wrap got=%h %h addr=%h", ifid_pc, ifid_pc4, imem_addr); end
    drive(0, 0, 0, 0, 32'h0, 1);
    cycle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL buf_fill got=%b exp=0", imem_req); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0);
    #1;
    total++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
      bad++; $display("FAIL reset_mid_stall got req=%b addr=%h", imem_req, imem_addr); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, {$urandom_range(0, 32'hFFFF), 2'b00}, $urandom_range(0, 3) != 0);
      cycle();
      total++;
      if ({imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !==
          {(m_buf.size() == 0) && !rst, m_pc, m_iv, m_ii, m_ip, m_ip4}) begin
        bad++;
        if (errs++ < 10) $display("FAIL random_%0d got req=%b addr=%h v=%b i=%h pc=%h pc4=%h exp addr=%h v=%b i=%h pc=%h",
          n, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc4, m_pc, m_iv, m_ii, m_ip);
      end
      total++;
      if ({stall_cnt, flush_cnt, bubble_cnt} !==
          (PERF ? {m_stall, m_flush, m_bubble} : 96'h0)) begin
        bad++;
        if (errs++ < 10) $display("FAIL random_cnt_%0d got=%0d %0d %0d exp=%0d %0d %0d", n,
          stall_cnt, flush_cnt, bubble_cnt, m_stall, m_flush, m_bubble);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_wait_states();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have pc_write  input  1  PC advance enable from hazard unit.
REQ-006 SHALL have ifid_write  input  1  IF/ID load enable from hazard unit.
REQ-007 SHALL have ifid_flush  input  1  IF/ID bubble insert from hazard unit.
REQ-008 SHALL have branch_taken  input  1  redirect request from EX.
REQ-009 SHALL have branch_target  input  32  redirect address.
REQ-010 SHALL have imem_req  output  1  fetch request, level.
REQ-011 SHALL have imem_addr  output  32  fetch address, equal to current PC.
REQ-012 SHALL have imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
REQ-013 SHALL have imem_rdata  input  32  fetched instruction.
REQ-014 SHALL have ifid_valid, ifid_instr[31:0], ifid_pc[31:0], ifid_pc4[31:0]  output  IF/ID register contents.
REQ-015 SHALL have stall_cnt, flush_cnt, bubble_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-016 SHALL define advance = pc_write & ifid_write; redirect = branch_taken | ifid_flush.
REQ-017 SHALL hold one-entry fetch buffer (buf_valid, buf_instr); imem_req = !buf_valid & !rst.
REQ-018 SHALL define fetch_ok = buf_valid | imem_ready; fetched = buf_valid ? buf_instr : imem_rdata.
REQ-019 PC update priority: branch_taken -> branch_target (overrides pc_write); else advance & fetch_ok -> PC+4 (mod 2^32 wrap); else hold.
REQ-020 IF/ID update priority: redirect -> valid=0, instr=NOP_INSTR, pc=0, pc4=0; else ifid_write & fetch_ok -> valid=1, instr=fetched, pc=PC, pc4=PC+4; else ifid_write & !fetch_ok -> bubble as redirect; else hold all fields.
REQ-021 Buffer update priority: redirect -> buf_valid=0; else buf_valid & advance -> buf_valid=0 (consumed); else !buf_valid & imem_ready & !advance -> buf_valid=1, buf_instr=imem_rdata; else hold.
REQ-022 Stall (advance=0) with imem_ready SHALL capture instruction once; no refetch until buffer consumed or discarded.
REQ-023 branch_taken with ifid_write=0 SHALL still bubble IF/ID and discard buffer (redirect wins over stall).
REQ-024 Latency: instruction at PC SHALL appear on ifid_* the edge after first cycle with fetch_ok & advance; zero-wait-state memory gives one instruction per cycle.
REQ-025 imem_addr SHALL change only at clock edges; imem_rdata sampled only when imem_ready=1.

Reset
REQ-026 On rst: PC=RESET_PC, buf_valid=0, buf_instr=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0, counters=0.
REQ-027 rst SHALL override all other inputs, including mid-stall and mid-redirect; first fetch at RESET_PC the cycle after rst deasserts.

Configuration
REQ-028 Macro IF_STAGE_PERF_EN: when defined, stall_cnt increments per cycle with !advance & !redirect, flush_cnt per cycle with redirect, bubble_cnt per cycle ifid_write & !redirect & !fetch_ok; all wrap at 2^32.
REQ-029 Without IF_STAGE_PERF_EN: counter ports present, tied to 32'h0, no counter flops.

Verification
REQ-030 Zero-wait imem, advance=1 from reset -> ifid_pc sequence 0,4,8,12 on consecutive edges, ifid_valid=1.
REQ-031 imem_ready=1, advance=0 for 3 cycles at PC=8 -> imem_req low after first cycle, buf_valid=1, ifid holds; release -> ifid_pc=8 with buffered instr, PC=12.
REQ-032 branch_taken=1, branch_target=0x100, ifid_flush=1 at PC=0x20 -> next edge ifid_valid=0, ifid_instr=0x00000013, imem_addr=0x100.
REQ-033 imem_ready=0 for 2 cycles at PC=4, advance=1 -> two bubbles, PC stays 4, then ifid_pc=4; with PERF_EN bubble_cnt=2.
REQ-034 PC=0xFFFF_FFFC, advance=1 -> next PC=0x0, ifid_pc4=0x0; rst asserted during stall with buf_valid=1 -> buf_valid=0, PC=RESET_PC.
